// File: rtl/bec_la_pkg.sv
// rtl/bec_la_pkg.sv - shared types and codes for the LA host sequencer
package bec_la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_SEND, ST_WAIT_ACK, ST_PROC, ST_RUN, ST_READ, ST_RELEASE
  } state_t;

  localparam logic [15:0] CMD_WREN    = 16'hAB40;
  localparam logic [15:0] CMD_PROC    = 16'hAB41;
  localparam logic [15:0] CMD_READ    = 16'hAB42;
  localparam logic [15:0] CMD_RELEASE = 16'hFFFF;

  localparam logic [5:0]  STS_LAST_ACK  = 6'b011110;
  localparam logic [5:0]  STS_BUSY      = 6'b100111;
  localparam logic [13:0] READ_TAG_BASE = 14'b11_0001_0000_0000;

  localparam int OP_W     = 163;
  localparam int HI_W     = 81;
  localparam int LO_W     = 82;
  localparam int N_OPS    = 7;
  localparam int N_CHUNKS = 14;

  // k ones in the low bits, k = 1..14
  function automatic logic [13:0] therm(input logic [3:0] k);
    return 14'((15'h1 << k) - 15'h1);
  endfunction

endpackage

// File: rtl/bec_la_timer.sv
// rtl/bec_la_timer.sv - loadable down-counter; expired once it reaches zero
module bec_la_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  // Loading N makes expired rise on the N-th cycle after the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val - W'(1);
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/bec_la_host.sv
// rtl/bec_la_host.sv - streams 7 operands to the core over LA, runs it, reads back X/Z
module bec_la_host
  import bec_la_pkg::*;
#(
  parameter int TIMEOUT    = 4096,
  parameter int ARM_CYCLES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              op_wr,
  input  logic [2:0]        op_addr,
  input  logic [OP_W-1:0]   op_data,
  input  logic              start,
  input  logic [127:0]      la_in,
  output logic [127:0]      la_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [OP_W-1:0]   res_x,
  output logic [OP_W-1:0]   res_z
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state, state_nx;
  logic [3:0]        k;
  logic [1:0]        s;
  logic [OP_W-1:0]   ops [N_OPS];
  logic [2:0]        op_idx;
  logic [OP_W-1:0]   cur_op;
  logic [127:0]      chunk;
  logic              ack, tag_hit, abort, expired, tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              unused_la;

  assign unused_la = ^la_in[31:0];
  assign busy      = (state != ST_IDLE);

  assign op_idx = 3'((k - 4'd1) >> 1);
  assign cur_op = (op_idx < 3'(N_OPS)) ? ops[op_idx] : '0;

  // Command field is placed last so it wins over operand bits [31:16].
  always_comb begin
    chunk = '0;
    if (k[0]) chunk[HI_W-1:0] = cur_op[OP_W-1:LO_W];
    else      chunk[LO_W-1:0] = cur_op[LO_W-1:0];
    chunk[95:82] = therm(k);
    chunk[31:16] = CMD_WREN;
  end

  assign ack = (k == 4'(N_CHUNKS)) ? (la_in[127:122] == STS_LAST_ACK)
                                   : (la_in[125:122] == k);
  assign tag_hit = (la_in[127:114] == READ_TAG_BASE + {4'b0, s, 8'b0});

  always_comb begin
    state_nx = state;
    la_out   = '0;
    abort    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_ARM;
      ST_ARM: begin
        la_out[31:16] = CMD_WREN;
        if (expired) state_nx = ST_SEND;
      end
      ST_SEND: begin
        la_out   = chunk;
        state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        la_out = chunk;
        if (ack) state_nx = (k == 4'(N_CHUNKS)) ? ST_PROC : ST_SEND;
        else     abort = expired;
      end
      ST_PROC: begin
        la_out[31:16] = CMD_PROC;
        if (la_in[127:122] == STS_BUSY) state_nx = ST_RUN;
        else                            abort = expired;
      end
      ST_RUN: begin
        if (la_in[127:122] != STS_BUSY) state_nx = ST_READ;
        else                            abort = expired;
      end
      ST_READ: begin
        la_out[31:16] = CMD_READ;
        la_out[15:0]  = {4'b0, s, 10'b0};
        if (tag_hit) begin
          if (s == 2'd3) state_nx = ST_RELEASE;
        end else begin
          abort = expired;
        end
      end
      ST_RELEASE: begin
        la_out[15:0] = CMD_RELEASE;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (abort) state_nx = ST_IDLE;
  end

  // Each read selector gets a fresh timeout window, not just each state.
  assign tmr_load = (state_nx != state) || (state == ST_READ && tag_hit);
  assign tmr_val  = (state_nx == ST_ARM) ? TW'(ARM_CYCLES) : TW'(TIMEOUT);

  bec_la_timer #(.W(TW)) u_timer (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= ST_IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      k     <= '0;
      s     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      res_x <= '0;
      res_z <= '0;
      for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
    end else begin
      done <= (state == ST_RELEASE);
      if (abort) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (op_wr && op_addr < 3'(N_OPS)) ops[op_addr] <= op_data;
          if (start) begin
            k   <= 4'd1;
            err <= 1'b0;
          end
        end
        ST_WAIT_ACK: if (ack) k <= k + 4'd1;
        ST_RUN:      if (state_nx == ST_READ) s <= '0;
        ST_READ: begin
          if (tag_hit) begin
            case (s)
              2'd0:    res_x[OP_W-1:HI_W] <= la_in[113:32];
              2'd1:    res_x[HI_W-1:0]    <= la_in[112:32];
              2'd2:    res_z[OP_W-1:HI_W] <= la_in[113:32];
              default: res_z[HI_W-1:0]    <= la_in[112:32];
            endcase
            s <= s + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bec_la_host.sv
// tb/tb_bec_la_host.sv - vector table plus scoreboard bench for bec_la_host
module tb_bec_la_host;

  localparam int TO = 200;
  localparam int AC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_wr = 1'b0;
  logic [2:0]   op_addr = '0;
  logic [162:0] op_data = '0;
  logic         start = 1'b0;
  logic [127:0] la_in = '0;
  logic [127:0] la_out;
  logic         busy, done, err;
  logic [162:0] res_x, res_z;

  bec_la_host #(.TIMEOUT(TO), .ARM_CYCLES(AC)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .op_wr(op_wr), .op_addr(op_addr),
    .op_data(op_data), .start(start), .la_in(la_in), .la_out(la_out),
    .busy(busy), .done(done), .err(err), .res_x(res_x), .res_z(res_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [162:0]     base;
    int               ack_dly;
    int               busy_cyc;
    logic [3:0][81:0] rd;
    bit               disturb;
  } vec_t;

  vec_t         vecs [3];
  logic [162:0] ops_m [7];
  logic [127:0] chunk_q [$];
  logic [325:0] res_q [$];
  int n_chk = 0, n_fail = 0, done_cnt = 0, done_exp = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_la(input logic [127:0] mask, input logic [127:0] val, input string name);
    int n = 0;
    while (((la_out & mask) !== val) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if ((la_out & mask) !== val) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: wait expired, la_out=%h", name, la_out);
    end
  endtask

  function automatic logic [13:0] therm_m(input int k);
    logic [13:0] t = '0;
    for (int i = 0; i < k; i++) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [127:0] chunk_word(input int k);
    logic [127:0] w = '0;
    logic [162:0] op = ops_m[(k - 1) / 2];
    if (k % 2 == 1) w[80:0] = op[162:82];
    else            w[81:0] = op[81:0];
    w[95:82] = therm_m(k);
    w[31:16] = 16'hAB40;
    return w;
  endfunction

  task automatic load_ops(input logic [162:0] base);
    for (int i = 0; i < 6; i++) begin
      ops_m[i] = base + 163'(i);
      op_wr = 1'b1; op_addr = 3'(i); op_data = ops_m[i];
      @(negedge clk);
    end
    op_addr = 3'd7; op_data = '1;
    @(negedge clk);
    op_wr = 1'b0;
  endtask

  task automatic run_transfer(input vec_t v, input int no_ack_k, input int rst_at_s, input string tg);
    logic [325:0] er;
    logic [127:0] ex;
    int n;
    ops_m[6] = v.base + 163'd6;
    for (int k = 1; k <= 14; k++) chunk_q.push_back(chunk_word(k));
    res_q.push_back({v.rd[0], v.rd[1][80:0], v.rd[2], v.rd[3][80:0]});
    op_wr = 1'b1; op_addr = 3'd6; op_data = ops_m[6]; start = 1'b1;
    @(negedge clk);
    op_wr = 1'b0; start = 1'b0;
    chk({tg, " arm_busy"}, 163'(busy), 163'(1));
    chk({tg, " err_cleared"}, 163'(err), 163'(0));
    chk({tg, " arm_word"}, 163'(la_out), 163'(128'hAB40_0000));
    n = 0;
    while (la_out[95:82] == '0 && n < 50) begin @(negedge clk); n++; end
    chk({tg, " arm_len"}, 163'(n), 163'(AC));
    for (int k = 1; k <= 14; k++) begin
      wait_la(128'h3FFF << 82, 128'(therm_m(k)) << 82, $sformatf("%s chunk%0d_wait", tg, k));
      la_in = '0;
      ex = chunk_q.pop_front();
      chk($sformatf("%s chunk%0d", tg, k), 163'(la_out), 163'(ex));
      if (k == no_ack_k) begin
        repeat (TO) @(negedge clk);
        chk({tg, " to_busy_last"}, 163'(busy), 163'(1));
        @(negedge clk);
        chk({tg, " to_busy"}, 163'(busy), 163'(0));
        chk({tg, " to_err"}, 163'(err), 163'(1));
        chk({tg, " to_la_out"}, 163'(la_out), 163'(0));
        chk({tg, " to_done"}, 163'(done), 163'(0));
        chunk_q.delete();
        res_q.delete();
        return;
      end
      if (v.disturb && k == 1) begin op_wr = 1'b1; op_addr = 3'd4; op_data = '1; end
      repeat (v.ack_dly) begin @(negedge clk); op_wr = 1'b0; end
      if (k < 14) la_in[125:122] = 4'(k);
      else        la_in[127:122] = 6'b011110;
    end
    wait_la(128'hFFFF << 16, 128'hAB41 << 16, {tg, " proc_wait"});
    la_in = '0;
    chk({tg, " proc_word"}, 163'(la_out), 163'(128'hAB41_0000));
    la_in[127:122] = 6'b100111;
    repeat (v.busy_cyc) @(negedge clk);
    chk({tg, " run_word"}, 163'(la_out), 163'(0));
    chk({tg, " run_busy"}, 163'(busy), 163'(1));
    la_in = '0;
    if (v.disturb) start = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_la(128'hFFFF_FFFF, 128'(32'hAB42_0000 | (s << 10)), $sformatf("%s read%0d_wait", tg, s));
      start = 1'b0;
      chk($sformatf("%s read%0d_word", tg, s), 163'(la_out), 163'(32'hAB42_0000 | (s << 10)));
      if (s == rst_at_s) begin
        rst_n = 1'b0;
        #1;
        chk({tg, " rst_la_out"}, 163'(la_out), 163'(0));
        chk({tg, " rst_busy"}, 163'(busy), 163'(0));
        chk({tg, " rst_flags"}, 163'({done, err}), 163'(0));
        chk({tg, " rst_res_x"}, res_x, 163'(0));
        chk({tg, " rst_res_z"}, res_z, 163'(0));
        chunk_q.delete();
        res_q.delete();
        for (int i = 0; i < 7; i++) ops_m[i] = '0;
        la_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      repeat (2) @(negedge clk);
      la_in = {14'h3100 + 14'(s << 8), v.rd[s], $urandom()};
    end
    wait_la(128'hFFFF, 128'hFFFF, {tg, " release_wait"});
    la_in = '0;
    chk({tg, " release_word"}, 163'(la_out), 163'(128'hFFFF));
    chk({tg, " release_flags"}, 163'({busy, done}), 163'(2'b10));
    @(negedge clk);
    chk({tg, " done_flags"}, 163'({busy, done}), 163'(2'b01));
    chk({tg, " idle_la_out"}, 163'(la_out), 163'(0));
    er = res_q.pop_front();
    chk({tg, " res_x"}, res_x, er[325:163]);
    chk({tg, " res_z"}, res_z, er[162:0]);
    done_exp++;
    @(negedge clk);
    chk({tg, " done_once"}, 163'(done), 163'(0));
  endtask

  initial begin
    vecs[0].base = 163'h1; vecs[0].ack_dly = 3; vecs[0].busy_cyc = 100; vecs[0].disturb = 0;
    vecs[1].base = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    vecs[1].ack_dly = 1; vecs[1].busy_cyc = 1; vecs[1].disturb = 1;
    vecs[2].base = 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    vecs[2].ack_dly = 6; vecs[2].busy_cyc = 20; vecs[2].disturb = 0;
    for (int s = 0; s < 4; s++) begin
      vecs[0].rd[s] = {2'b10, {10{8'hA5}}} ^ 82'(s);
      vecs[1].rd[s] = 82'({$urandom(), $urandom(), $urandom()});
      vecs[2].rd[s] = 82'({$urandom(), $urandom(), $urandom()});
    end
    for (int i = 0; i < 7; i++) ops_m[i] = '0;

    repeat (2) @(negedge clk);
    chk("reset la_out", 163'(la_out), 163'(0));
    chk("reset flags", 163'({busy, done, err}), 163'(0));
    chk("reset res_x", res_x, 163'(0));
    chk("reset res_z", res_z, 163'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      load_ops(vecs[i].base);
      run_transfer(vecs[i], 0, -1, $sformatf("vec%0d", i));
    end

    run_transfer(vecs[2], 5, -1, "timeout");
    repeat (5) @(negedge clk);
    chk("err sticky", 163'(err), 163'(1));
    chk("no done after timeout", 163'(done_cnt), 163'(done_exp));

    load_ops(vecs[0].base);
    run_transfer(vecs[0], 0, -1, "after_to");

    load_ops(vecs[1].base);
    run_transfer(vecs[1], 0, 2, "rst_read");
    run_transfer(vecs[0], 0, -1, "after_rst");

    chk("done pulse count", 163'(done_cnt), 163'(done_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
